// File: rtl/clock_divider_ctrl_if.sv
// Configuration handshake for clock_divider_ctrl: a requester offers a new
// half-period with cfg_valid/cfg_half, and the divider answers with cfg_ready.
interface clock_divider_ctrl_if #(
  parameter int W = 11
) ();
  logic         cfg_valid;
  logic [W-1:0] cfg_half;
  logic         cfg_ready;

  modport master (output cfg_valid, output cfg_half, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_half, output cfg_ready);
endinterface

// File: rtl/clock_divider_ctrl.sv
// Run/stop controller around a counter-based clock divider. The half-period is
// reprogrammable at run time and only changes at full-period boundaries.
module clock_divider_ctrl #(
  parameter  int MAX_HALF     = 1024,
  parameter  int DEFAULT_HALF = 4,
  localparam int W            = $clog2(MAX_HALF + 1)
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic                        en,
  clock_divider_ctrl_if.slave         cfg,
  output logic                        clk_out,
  output logic                        tick,
  output logic                        busy,
  output logic [W-1:0]                half_cur
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_out_q, clk_out_d;
  logic         tick_q, tick_d;
  logic [W-1:0] half_q, half_d;
  logic         pend_q, pend_d;
  logic [W-1:0] pend_val_q, pend_val_d;
  logic         term;
  logic         apply_ok;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      half_q     <= W'(DEFAULT_HALF);
      pend_q     <= 1'b0;
      pend_val_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      half_q     <= half_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;
    half_d     = half_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    apply_ok   = 1'b0;
    term       = (cnt_q == half_q - W'(1));

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        apply_ok  = 1'b1;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en && !clk_out_q) begin
          // Stopping in the low phase truncates it; no edge reaches clk_out.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (term) begin
          cnt_d     = '0;
          clk_out_d = !clk_out_q;
          tick_d    = !clk_out_q;
          apply_ok  = clk_out_q;
          if (clk_out_q && !en) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + W'(1);
          if (!en) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (term) begin
          cnt_d     = '0;
          clk_out_d = 1'b0;
          apply_ok  = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase

    if (pend_q && apply_ok) begin
      half_d = pend_val_q;
      pend_d = 1'b0;
    end

    if (cfg.cfg_valid && !pend_q) begin
      pend_d = 1'b1;
      if (cfg.cfg_half == '0)
        pend_val_d = W'(1);
      else if (cfg.cfg_half > W'(MAX_HALF))
        pend_val_d = W'(MAX_HALF);
      else
        pend_val_d = cfg.cfg_half;
    end
  end

  assign cfg.cfg_ready = !pend_q;
  assign clk_out       = clk_out_q;
  assign tick          = tick_q;
  assign busy          = (state_q != IDLE);
  assign half_cur      = half_q;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Bench for clock_divider_ctrl: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a phase-timing model.
module tb_clock_divider_ctrl;
  localparam int MAX_HALF     = 1024;
  localparam int DEFAULT_HALF = 4;
  localparam int W            = $clog2(MAX_HALF + 1);

  logic         clk_in = 1'b0;
  logic         reset  = 1'b1;
  logic         en     = 1'b0;
  logic         clk_out, tick, busy;
  logic [W-1:0] half_cur;

  int checks = 0;
  int errors = 0;

  clock_divider_ctrl_if #(.W(W)) cfg ();

  clock_divider_ctrl #(
    .MAX_HALF     (MAX_HALF),
    .DEFAULT_HALF (DEFAULT_HALF)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .en       (en),
    .cfg      (cfg.slave),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy),
    .half_cur (half_cur)
  );

  always #5 clk_in = !clk_in;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks whether the divider is running, the output level, how many
  // cycles of the current phase have elapsed, and whether a stop is pending.
  bit      m_ok = 0;
  bit      m_on, m_stop, m_out, m_tick, m_pend;
  int      m_el, m_half, m_pval;

  function automatic int clampv(input int v);
    if (v == 0) return 1;
    if (v > MAX_HALF) return MAX_HALF;
    return v;
  endfunction

  always @(posedge clk_in) begin
    bit acc;
    int aval;
    if (reset) begin
      m_ok = 1; m_on = 0; m_stop = 0; m_out = 0; m_tick = 0;
      m_pend = 0; m_el = 0; m_half = DEFAULT_HALF; m_pval = 0;
    end else if (m_ok) begin
      acc  = cfg.cfg_valid && !m_pend;
      aval = clampv(int'(cfg.cfg_half));
      m_tick = 0;
      if (!m_on) begin
        if (m_pend) begin m_half = m_pval; m_pend = 0; end
        m_on = en; m_el = 0; m_out = 0;
      end else if (!m_out && !en && !m_stop) begin
        m_on = 0; m_el = 0;
      end else if (m_el + 1 == m_half) begin
        if (m_out) begin
          if (m_pend) begin m_half = m_pval; m_pend = 0; end
          if (!en || m_stop) begin m_on = 0; m_stop = 0; end
        end else begin
          m_tick = 1;
        end
        m_out = !m_out;
        m_el  = 0;
      end else begin
        m_el++;
        if (!en) m_stop = 1;
      end
      if (acc) begin m_pend = 1; m_pval = aval; end
    end
  end

  always @(negedge clk_in) begin
    if (m_ok) begin
      chk("clk_out",   int'(clk_out),       int'(m_out));
      chk("tick",      int'(tick),          int'(m_tick));
      chk("busy",      int'(busy),          int'(m_on));
      chk("half_cur",  int'(half_cur),      m_half);
      chk("cfg_ready", int'(cfg.cfg_ready), int'(!m_pend));
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Counts posedges until clk_out reaches v; an expired budget counts as a failure.
  task automatic wait_clk(input logic v, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (clk_out !== v && n < 5000);
    if (clk_out !== v) begin
      checks++; errors++;
      $display("FAIL wait_clk: clk_out stuck at %0b, expected %0b", clk_out, v);
    end
  endtask

  initial begin
    int n, m;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_half  = '0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_clk_out",   int'(clk_out), 0);
    chk("rst_busy",      int'(busy), 0);
    chk("rst_half",      int'(half_cur), DEFAULT_HALF);
    chk("rst_ready",     int'(cfg.cfg_ready), 1);

    // Default run: rise 1+N after en is sampled, then 4 high / 4 low.
    en = 1'b1;
    wait_clk(1'b1, n); chk("first_rise_lat", n, 5);
    chk("tick_on_rise", int'(tick), 1);
    chk("busy_run", int'(busy), 1);
    wait_clk(1'b0, n); chk("high_len4", n, 4);
    wait_clk(1'b1, n); chk("low_len4", n, 4);

    // Ratio change offered during the high phase.
    cfg.cfg_valid = 1'b1; cfg.cfg_half = W'(2);
    step(); cfg.cfg_valid = 1'b0;
    chk("ready_drop", int'(cfg.cfg_ready), 0);
    wait_clk(1'b0, m); chk("high_kept4", m + 1, 4);
    chk("half_after_apply", int'(half_cur), 2);
    chk("ready_after_apply", int'(cfg.cfg_ready), 1);
    wait_clk(1'b1, n); chk("low_len2", n, 2);
    wait_clk(1'b0, n); chk("high_len2", n, 2);

    // Back to N=4, then stop at counter 1 of a high phase.
    cfg.cfg_valid = 1'b1; cfg.cfg_half = W'(4);
    step(); cfg.cfg_valid = 1'b0;
    n = 0;
    while (half_cur != W'(4) && n < 100) begin step(); n++; end
    chk("half_back4", int'(half_cur), 4);
    wait_clk(1'b1, n);
    step();
    en = 1'b0;
    step();
    chk("drain_busy", int'(busy), 1);
    chk("drain_high", int'(clk_out), 1);
    wait_clk(1'b0, n); chk("drain_len", n, 2);
    chk("drain_idle", int'(busy), 0);

    // Stop during the low phase.
    en = 1'b1;
    wait_clk(1'b1, n); chk("restart_lat", n, 5);
    wait_clk(1'b0, n); chk("restart_high", n, 4);
    en = 1'b0;
    step();
    chk("lowstop_busy", int'(busy), 0);
    chk("lowstop_clk", int'(clk_out), 0);

    // Clamp 0 -> 1, then divide by 2.
    cfg.cfg_valid = 1'b1; cfg.cfg_half = '0;
    step(); cfg.cfg_valid = 1'b0;
    chk("clamp0_ready", int'(cfg.cfg_ready), 0);
    step();
    chk("clamp0_half", int'(half_cur), 1);
    chk("clamp0_ready1", int'(cfg.cfg_ready), 1);
    en = 1'b1;
    wait_clk(1'b1, n); chk("n1_lat", n, 2);
    wait_clk(1'b0, n); chk("n1_high", n, 1);
    wait_clk(1'b1, n); chk("n1_low", n, 1);
    en = 1'b0;
    step();
    chk("n1_stop_busy", int'(busy), 0);
    chk("n1_stop_clk", int'(clk_out), 0);

    // Clamp to MAX_HALF and back-pressure on a second offer.
    cfg.cfg_valid = 1'b1; cfg.cfg_half = W'(2000);
    step();
    cfg.cfg_half = W'(7);
    step();
    cfg.cfg_valid = 1'b0;
    chk("clampmax_half", int'(half_cur), MAX_HALF);
    step();
    chk("backpressure_half", int'(half_cur), MAX_HALF);
    chk("backpressure_ready", int'(cfg.cfg_ready), 1);

    // Reset while draining with a pending value.
    cfg.cfg_valid = 1'b1; cfg.cfg_half = W'(4);
    step(); cfg.cfg_valid = 1'b0;
    step();
    en = 1'b1;
    wait_clk(1'b1, n); chk("pre_rst_lat", n, 5);
    en = 1'b0; cfg.cfg_valid = 1'b1; cfg.cfg_half = W'(9);
    step(); cfg.cfg_valid = 1'b0;
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_ready", int'(cfg.cfg_ready), 0);
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("mid_rst_clk", int'(clk_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_half", int'(half_cur), DEFAULT_HALF);
    chk("mid_rst_ready", int'(cfg.cfg_ready), 1);
    step();
    chk("pending_dropped", int'(half_cur), DEFAULT_HALF);

    // Random traffic checked by the model.
    for (int i = 0; i < 4000; i++) begin
      int r;
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) < 4) en = !en;
      cfg.cfg_valid = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 59);
      if (r == 0)      cfg.cfg_half = '0;
      else if (r == 1) cfg.cfg_half = W'(1025 + $urandom_range(0, 900));
      else if (r == 2) cfg.cfg_half = W'($urandom_range(20, 40));
      else             cfg.cfg_half = W'($urandom_range(1, 6));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
